// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation modes and default datapath geometry.
package alu_pkg;

  localparam logic MODE_ADD   = 1'b0;
  localparam logic MODE_SUB   = 1'b1;
  localparam int   DEF_WIDTH  = 8;
  localparam int   DEF_STAGES = 2;

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple adder; also exposes the carry into its MSB for overflow detection.
module adder_seg #(
  parameter int SEG = 4
) (
  input  logic           cin_i,
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o,
  output logic           cmsb_o
);

  logic [SEG:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < SEG; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = carry[SEG];
  assign cmsb_o = carry[SEG-1];

endmodule

// File: rtl/adder_sub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG-bit slice per stage, carry rippled through registers,
// valid/ready flow control with a single global advance enable.
module adder_sub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out,
  output logic             v_out,
  output logic             z_out
);

  localparam int SEG = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}});

  logic en;

  logic [STAGES-1:0]            valid_src, sub_src, cin_src;
  logic [STAGES-1:0]            valid_q, sub_q, c_q;
  logic [STAGES-1:0]            seg_cout, seg_cmsb;
  logic [STAGES-1:0][WIDTH-1:0] a_src, b_src, s_src, s_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
  logic [STAGES-1:0][SEG-1:0]   seg_sum;

  logic c_out_d, v_out_d, z_out_d;
  logic c_out_q, v_out_q, z_out_q;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  for (genvar gi = 0; gi < STAGES; gi++) begin : stage_g
    if (gi == 0) begin : head_g
      // Subtraction is folded in up front: B and the borrow are inverted once at entry.
      assign valid_src[gi] = in_valid;
      assign sub_src[gi]   = in_sub;
      assign cin_src[gi]   = (in_sub == MODE_SUB) ? ~in_c : in_c;
      assign a_src[gi]     = in_a;
      assign b_src[gi]     = (in_sub == MODE_SUB) ? ~in_b : in_b;
      assign s_src[gi]     = '0;
    end else begin : link_g
      assign valid_src[gi] = valid_q[gi-1];
      assign sub_src[gi]   = sub_q[gi-1];
      assign cin_src[gi]   = c_q[gi-1];
      assign a_src[gi]     = a_q[gi-1];
      assign b_src[gi]     = b_q[gi-1];
      assign s_src[gi]     = s_q[gi-1];
    end

    adder_seg #(.SEG(SEG)) u_seg (
      .cin_i  (cin_src[gi]),
      .a_i    (a_src[gi][gi*SEG +: SEG]),
      .b_i    (b_src[gi][gi*SEG +: SEG]),
      .sum_o  (seg_sum[gi]),
      .cout_o (seg_cout[gi]),
      .cmsb_o (seg_cmsb[gi])
    );

    assign s_d[gi] = (s_src[gi] & ~(SEG_MASK << (gi*SEG)))
                   | (WIDTH'(seg_sum[gi]) << (gi*SEG));
  end

  // Flags come from the last slice, before the borrow inversion for overflow.
  assign c_out_d = (sub_src[STAGES-1] == MODE_SUB) ? ~seg_cout[STAGES-1] : seg_cout[STAGES-1];
  assign v_out_d = seg_cmsb[STAGES-1] ^ seg_cout[STAGES-1];
  assign z_out_d = ~|s_d[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      sub_q   <= '0;
      c_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      v_out_q <= 1'b0;
      z_out_q <= 1'b0;
    end else if (en) begin
      valid_q <= valid_src;
      sub_q   <= sub_src;
      c_q     <= seg_cout;
      a_q     <= a_src;
      b_q     <= b_src;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      v_out_q <= v_out_d;
      z_out_q <= z_out_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign s_out     = s_q[STAGES-1];
  assign c_out     = c_out_q;
  assign v_out     = v_out_q;
  assign z_out     = z_out_q;

  // The final stage's operand/carry/mode copies have no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], c_q[STAGES-1], sub_q[STAGES-1]};

endmodule

// File: doc/adder_sub_pipe.md
# adder_sub_pipe

Parametrised, pipelined N-bit adder/subtractor with borrow/carry-in, valid/ready flow control and status flags. Successor to the single-bit registered full adder core: WIDTH-bit operands split into STAGES equal segments, one segment resolved per clock, carry rippled between stages through registers. Sits behind the dff_sync input synchronisers as the arithmetic datapath of the ALU.

## Interface
- WIDTH, 8: operand/result width in bits; WIDTH % STAGES == 0
- STAGES, 2: pipeline depth, 1..WIDTH; SEG = WIDTH/STAGES bits per stage
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept operands this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_c  in  1  carry-in (add) / borrow-in (sub)
- in_sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result this cycle
- s_out  out  WIDTH  sum/difference
- c_out  out  1  carry-out (add) / borrow-out (sub)
- v_out  out  1  signed overflow
- z_out  out  1  s_out == 0

## Operation
- Add: s = A + B + in_c; c_out = carry out of MSB.
- Sub: s = A + ~B + ~in_c (i.e. A − B − in_c); c_out = ~(carry out of MSB), 1 = borrow.
- v_out = carry into MSB XOR carry out of MSB (pre-inversion); z_out = ~|s_out.
- All arithmetic modulo 2^WIDTH; no saturation.
- Stage k (0..STAGES−1) adds bits [k*SEG +: SEG] using the registered carry from stage k−1 (stage 0 uses effective carry-in).
- Unconsumed upper operand segments travel in skew registers; completed lower result segments travel in deskew registers; in_sub travels with each op.
- Flags computed in the final stage, registered together with s_out.
- Per-stage valid bit; bubbles are not collapsed.

## Timing
- Global advance enable en = ~out_valid | out_ready; in_ready = en (combinational from out_valid register and out_ready).
- Op accepted on a rising edge with in_valid & in_ready; result at the outputs exactly STAGES enabled edges later with out_valid = 1.
- Throughput: one op per cycle when out_ready held high.
- Stall (out_valid & ~out_ready): all stage registers and outputs hold; in_ready = 0; nothing lost or duplicated.
- in_valid = 0 while en: a bubble (valid 0) enters stage 0.
- Outputs change only on rising clk edges; all outputs registered except in_ready.
- Reset (rst_n low, any time, asynchronous): every valid bit, s_out, c_out, v_out, z_out cleared to 0 immediately; in-flight ops discarded; in_ready = 1 after reset (out_valid = 0). Release takes effect at the next rising edge.
- STAGES = 1: single register stage, latency 1.
- STAGES = WIDTH: one bit per stage, latency WIDTH.

## Structure
- Shared package alu_pkg: MODE_ADD = 1'b0, MODE_SUB = 1'b1, default WIDTH/STAGES constants.
- One sub-module, adder_seg: combinational SEG-bit ripple adder (cin, a, b → sum, cout, carry into MSB), instantiated once per stage via generate.
- Top level holds the per-stage registers, skew/deskew shift structures, valid chain, enable logic and flag generation.

## Test plan
- WIDTH=8, STAGES=2: add A=8'h7F, B=8'h01, in_c=0 → 2 cycles later s_out=8'h80, c_out=0, v_out=1, z_out=0.
- Sub A=8'h00, B=8'h01, in_c=0 → s_out=8'hFF, c_out=1, v_out=0, z_out=0; sub A=8'h05, B=8'h03, in_c=1 → s_out=8'h01, c_out=0.
- Add A=8'hFF, B=8'h00, in_c=1 → s_out=8'h00, c_out=1, z_out=1, v_out=0 (carry crossing segment boundary).
- Back-to-back 4 ops (mixed add/sub) on consecutive cycles, out_ready=1 → 4 results on 4 consecutive cycles, in order, matching reference model.
- out_ready low 3 cycles while out_valid=1 and 2 ops queued → outputs stable, in_ready=0, all 3 results delivered in order after release.
- rst_n pulsed low mid-stream with 2 ops in flight → out_valid and all outputs 0 immediately; no stale result after release; next op completes in 2 cycles. Repeat full suite for STAGES=1, 4, 8.
